// File: rtl/keypad_display_mux.sv
// Two-digit key history with a time-multiplexed 7-segment driver (show/gap phases).
// Optional per-digit blanking of never-loaded digits is enabled by defining DIGIT_BLANKING_EN.
module keypad_display_mux #(
  parameter int REFRESH_CYCLES = 1000,
  parameter int GAP_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [6:0] seg,
  output logic       select0,
  output logic       select1
);

  localparam logic [1:0] ST_SHOW0 = 2'd0;
  localparam logic [1:0] ST_GAP0  = 2'd1;
  localparam logic [1:0] ST_SHOW1 = 2'd2;
  localparam logic [1:0] ST_GAP1  = 2'd3;

  localparam logic [15:0] SHOW_LAST = 16'(REFRESH_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  logic [1:0]  state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [15:0] phase_last;
  logic [3:0]  digit0_reg, digit1_reg;
  logic [6:0]  seg_reg, seg_next;
  logic        select0_reg, select0_next;
  logic        select1_reg, select1_next;
  logic        show0_en, show1_en;

  function automatic logic [6:0] decode_hex(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b1000000;
      4'h1:    pattern = 7'b1111001;
      4'h2:    pattern = 7'b0100100;
      4'h3:    pattern = 7'b0110000;
      4'h4:    pattern = 7'b0011001;
      4'h5:    pattern = 7'b0010010;
      4'h6:    pattern = 7'b0000010;
      4'h7:    pattern = 7'b1111000;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0010000;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b0000011;
      4'hC:    pattern = 7'b1000110;
      4'hD:    pattern = 7'b0100001;
      4'hE:    pattern = 7'b0000110;
      default: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

  // Phase sequencer: the state encoding is ordered so that +1 walks the cycle.
  always_comb begin
    phase_last = ((state_reg == ST_SHOW0) || (state_reg == ST_SHOW1)) ? SHOW_LAST : GAP_LAST;
    state_next = state_reg;
    count_next = count_reg + 16'd1;
    if (count_reg >= phase_last) begin
      state_next = state_reg + 2'd1;
      count_next = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_SHOW0;
      count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit0_reg <= 4'd0;
      digit1_reg <= 4'd0;
    end else if (key_valid) begin
      digit1_reg <= digit0_reg;
      digit0_reg <= key_code;
    end
  end

`ifdef DIGIT_BLANKING_EN
  logic valid0_reg, valid1_reg;

  // valid1 follows valid0 through the shift, so a digit lights only once it holds a real key.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid0_reg <= 1'b0;
      valid1_reg <= 1'b0;
    end else if (key_valid) begin
      valid0_reg <= 1'b1;
      if (valid0_reg) begin
        valid1_reg <= 1'b1;
      end
    end
  end

  assign show0_en = valid0_reg;
  assign show1_en = valid1_reg;
`else
  assign show0_en = 1'b1;
  assign show1_en = 1'b1;
`endif

  always_comb begin
    seg_next     = SEG_BLANK;
    select0_next = 1'b0;
    select1_next = 1'b0;
    case (state_reg)
      ST_SHOW0: begin
        select0_next = 1'b1;
        if (show0_en) begin
          seg_next = decode_hex(digit0_reg);
        end
      end
      ST_SHOW1: begin
        select1_next = 1'b1;
        if (show1_en) begin
          seg_next = decode_hex(digit1_reg);
        end
      end
      default: begin
        seg_next = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_reg     <= SEG_BLANK;
      select0_reg <= 1'b0;
      select1_reg <= 1'b0;
    end else begin
      seg_reg     <= seg_next;
      select0_reg <= select0_next;
      select1_reg <= select1_next;
    end
  end

  assign digit0  = digit0_reg;
  assign digit1  = digit1_reg;
  assign seg     = seg_reg;
  assign select0 = select0_reg;
  assign select1 = select1_reg;

endmodule

// File: doc/keypad_display_mux.md
KEYPAD_DISPLAY_MUX -- requirements
Module: keypad_display_mux

Interface
REQ-001 The block SHALL provide parameter REFRESH_CYCLES, default 1000, giving clk cycles per digit-on phase (legal range 2..65535).
REQ-002 The block SHALL provide parameter GAP_CYCLES, default 8, giving clk cycles of blanking between digit phases (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe from the debouncer marking a new key.
REQ-006 The block SHALL have port key_code, input, 4 bits: hex value of the key, sampled only when key_valid=1.
REQ-007 The block SHALL have port digit0, output, 4 bits: newest key value (right digit).
REQ-008 The block SHALL have port digit1, output, 4 bits: previous key value (left digit).
REQ-009 The block SHALL have port seg, output, 7 bits: active-low segments, bit order g,f,e,d,c,b,a (bit 6 down to bit 0).
REQ-010 The block SHALL have port select0, output, 1 bit: active-high enable for the right digit.
REQ-011 The block SHALL have port select1, output, 1 bit: active-high enable for the left digit.

Function
REQ-012 On key_valid=1, the block SHALL load digit1 with digit0 and digit0 with key_code on the same rising edge. The new values SHALL be visible one cycle after the strobe.
REQ-013 key_valid high on consecutive cycles SHALL be treated as separate keys, with one shift per cycle.
REQ-014 The phase FSM SHALL run SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0.
  - SHOW0 and SHOW1 each last REFRESH_CYCLES cycles.
  - GAP0 and GAP1 each last GAP_CYCLES cycles.
REQ-015 A phase counter SHALL count 0..(length-1), reset to 0 on each phase change, and never exceed the current phase length.
REQ-016 In SHOW0 the outputs SHALL be select0=1, select1=0, seg=decode(digit0).
REQ-017 In SHOW1 the outputs SHALL be select0=0, select1=1, seg=decode(digit1).
REQ-018 In GAP0 and GAP1 the outputs SHALL be select0=0, select1=0, seg=7'b1111111.
REQ-019 select0 and select1 SHALL never be 1 in the same cycle.
REQ-020 seg, select0 and select1 SHALL be registered, lagging the FSM state by exactly one cycle.
REQ-021 The decoder SHALL map 0..F to these active-low patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
REQ-022 A key arriving mid-SHOW phase SHALL change seg within that same phase, at the one-cycle output latency. The phase timing SHALL be unaffected.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL set:
  - FSM=SHOW0, phase counter=0
  - digit0=0, digit1=0
  - seg=1111111, select0=0, select1=0
REQ-024 Reset SHALL take priority over a simultaneous key_valid, and that key SHALL be discarded.
REQ-025 Reset asserted mid-phase SHALL abort the phase. SHOW0 SHALL restart from count 0 on the first edge after reset deasserts.

Configuration
REQ-026 Macro DIGIT_BLANKING_EN SHALL control per-digit blanking as follows.
  - Defined: the block SHALL keep a valid flag per digit, cleared by reset.
    - valid0 is set on any key.
    - valid1 is set on a key arriving while valid0=1.
    - A SHOW phase whose digit is not valid SHALL output seg=1111111 with its select still asserted.
  - Undefined: no valid flags; both digits always display, showing "0" after reset.

Verification (REFRESH_CYCLES=4, GAP_CYCLES=2)
REQ-027 Reset: hold reset=1 for 3 cycles, then release -> select0=1 from the 2nd cycle after release for 4 cycles, then 2 cycles both selects 0, then select1=1 for 4 cycles; period 12 cycles; seg=1000000 in both SHOW phases (macro undefined).
REQ-028 Single key: key_valid=1 with key_code=5 -> digit0=5 and digit1=0 the next cycle; seg=0010010 whenever select0=1.
REQ-029 History shift: strobe A, then 3 cycles later strobe 7 -> digit1=A, digit0=7; seg=0001000 with select1=1 and seg=1111000 with select0=1.
REQ-030 Back-to-back and collision: strobes on consecutive cycles with codes 1,2,3 -> digit1=2, digit0=3. A strobe with code F coincident with reset=1 -> digits 0,0.
REQ-031 Blanking (macro defined): after reset, seg=1111111 in both SHOW phases. One key 9 -> SHOW0 shows 0010000 and SHOW1 stays 1111111. A second key makes both digits visible.
